// File: rtl/wallace_mul_sched.sv
// Round-robin scheduler for two requesters sharing one external signed 32x32 multiplier.
// Results are held in a credit-protected FIFO; a halt/drain handshake quiesces the datapath.
module wallace_mul_sched #(
  parameter int unsigned MUL_LAT    = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req0_hi,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic        req1_hi,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        halt_req,
  output logic        halt_ack,
  output logic [31:0] issue_cnt
);

  localparam int unsigned SLEN = MUL_LAT + 1;
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned OW   = $clog2(FIFO_DEPTH + SLEN + 1) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed { logic id; logic hi; } tag_t;
  typedef struct packed { logic id; logic [31:0] data; } rsp_t;

  state_t          state_q, state_d;
  logic            rr_q;
  logic [SLEN-1:0] inf_v_q;
  tag_t            inf_tag_q [SLEN];
  rsp_t            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q;

  logic [OW-1:0]   inflight_c, outstanding_c;
  logic            can_issue_c, grant_c, accept_c, capture_c, pop_c;
  tag_t            issue_tag_c;
  rsp_t            cap_entry_c;

  // Products in the multiplier pipeline plus results queued must fit the FIFO.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < int'(SLEN); i++) begin
      inflight_c = inflight_c + OW'(inf_v_q[i]);
    end
  end

  assign outstanding_c = inflight_c + OW'(fifo_cnt_q);
  assign can_issue_c   = !rst && (state_q == RUN) && !halt_req &&
                         (outstanding_c < OW'(FIFO_DEPTH));
  assign grant_c       = req1_valid && (!req0_valid || rr_q);
  assign req0_ready    = can_issue_c && !grant_c;
  assign req1_ready    = can_issue_c && grant_c;
  assign accept_c      = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    issue_tag_c    = '0;
    issue_tag_c.id = grant_c;
    issue_tag_c.hi = grant_c ? req1_hi : req0_hi;
  end

  assign capture_c = inf_v_q[MUL_LAT];
  always_comb begin
    cap_entry_c      = '0;
    cap_entry_c.id   = inf_tag_q[MUL_LAT].id;
    cap_entry_c.data = inf_tag_q[MUL_LAT].hi ? mul_r[63:32] : mul_r[31:0];
  end

  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_id    = fifo_q[rd_ptr_q].id;
  assign rsp_data  = fifo_q[rd_ptr_q].data;
  assign pop_c     = rsp_valid && rsp_ready;

  // Operand issue, round-robin pointer and in-flight tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x     <= '0;
      mul_y     <= '0;
      rr_q      <= 1'b0;
      issue_cnt <= '0;
      inf_v_q   <= '0;
      for (int i = 0; i < int'(SLEN); i++) inf_tag_q[i] <= '0;
    end else begin
      inf_v_q[0]   <= accept_c;
      inf_tag_q[0] <= issue_tag_c;
      for (int i = 1; i < int'(SLEN); i++) begin
        inf_v_q[i]   <= inf_v_q[i-1];
        inf_tag_q[i] <= inf_tag_q[i-1];
      end
      if (accept_c) begin
        mul_x     <= grant_c ? req1_x : req0_x;
        mul_y     <= grant_c ? req1_y : req0_y;
        rr_q      <= !grant_c;
        issue_cnt <= issue_cnt + 32'd1;
      end
    end
  end

  // Result FIFO; overflow cannot happen because issue is credit-limited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      if (capture_c) begin
        fifo_q[wr_ptr_q] <= cap_entry_c;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(capture_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      halt_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      halt_ack <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN: begin
        if (!halt_req)                                   state_d = RUN;
        else if ((inflight_c == '0) && (fifo_cnt_q == '0)) state_d = HALTED;
      end
      HALTED:  if (!halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

endmodule
